// File: rtl/alu_issue_arbiter_pkg.sv
// Shared definitions for the two-requester ALU issue arbiter: opcodes,
// flag bit positions, the in-flight tag record and the arbitration rule.
package alu_issue_arbiter_pkg;

    // ALU opcodes understood by the downstream ALU wrapper.
    localparam logic [4:0] OP_ADD = 5'd0;
    localparam logic [4:0] OP_SUB = 5'd1;
    localparam logic [4:0] OP_MUL = 5'd2;
    localparam logic [4:0] OP_DIV = 5'd4;
    localparam logic [4:0] OP_SHL = 5'd6;
    localparam logic [4:0] OP_SHR = 5'd7;

    // Bit positions inside the 4-bit {zero, neg, carry, overflow} flag vector.
    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Deepest ALU latency the tag pipeline and inflight counter are sized for.
    localparam int MAX_LAT = 8;

    // One in-flight operation: whether the slot is occupied and who owns it.
    typedef struct packed {
        logic valid;
        logic id;
    } tag_t;

    // Round-robin pick between two requesters: on contention the one that
    // did not win last time is chosen; otherwise the only valid one wins.
    function automatic logic rr_pick(input logic v0, input logic v1, input logic last);
        if (v0 && v1) return ~last;
        return v1;
    endfunction

endpackage

// File: rtl/alu_tag_pipe.sv
// LAT-deep shift register of in-flight tags. The head of the pipe lines up
// with the ALU result for the operation that entered LAT cycles earlier.
module alu_tag_pipe
    import alu_issue_arbiter_pkg::*;
#(
    parameter int LAT = 2
) (
    input  logic clk,
    input  logic rst,
    input  tag_t tag_in,
    output tag_t tag_out
);

    tag_t stages [LAT];

    // Advance every tag by one stage per cycle; reset drops all tags in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: this array is reset on purpose -- its valid bits decide
            // whether a response is emitted, so stale contents are not harmless.
            for (int i = 0; i < LAT; i++) stages[i] <= '0;
        end else begin
            stages[0] <= tag_in;
            for (int i = 1; i < LAT; i++) stages[i] <= stages[i-1];
        end
    end

    assign tag_out = stages[LAT-1];

endmodule

// File: rtl/alu_issue_arbiter.sv
// Round-robin arbiter that lets two requesters share one pipelined ALU.
// Grants are combinational, issue registers feed the ALU, and a tag pipe
// returns each result to the requester that issued it.
module alu_issue_arbiter
    import alu_issue_arbiter_pkg::*;
#(
    parameter int DW  = 8,
    parameter int BW  = 5,
    parameter int OPW = 5,
    parameter int LAT = 2,
    parameter int CW  = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           hold,
    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic [DW-1:0]  req0_a,
    input  logic [BW-1:0]  req0_b,
    input  logic [OPW-1:0] req0_op,
    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [DW-1:0]  req1_a,
    input  logic [BW-1:0]  req1_b,
    input  logic [OPW-1:0] req1_op,
    output logic           alu_issue,
    output logic [DW-1:0]  alu_a,
    output logic [BW-1:0]  alu_b,
    output logic [OPW-1:0] alu_op,
    input  logic [DW-1:0]  alu_result,
    input  logic [3:0]     alu_flags,
    output logic           rsp_valid,
    output logic           rsp_id,
    output logic [DW-1:0]  rsp_data,
    output logic [3:0]     rsp_flags,
    output logic [3:0]     inflight,
    output logic [CW-1:0]  issue_cnt
);

    logic last_grant;
    logic issue_id;
    logic grant_valid;
    logic grant_id;
    tag_t issue_tag;
    tag_t rsp_tag;

    // Pick this cycle's winner; nothing is granted while hold is high.
    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no
        // latch is inferred.
        grant_valid = 1'b0;
        grant_id    = 1'b0;
        if (!hold && (req0_valid || req1_valid)) begin
            grant_valid = 1'b1;
            grant_id    = rr_pick(req0_valid, req1_valid, last_grant);
        end
    end

    assign req0_ready = grant_valid && !grant_id;
    assign req1_ready = grant_valid &&  grant_id;

    // Capture the granted operation into the ALU issue registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: state is updated with <= only, so every register here
            // sees the pre-edge values of the others.
            alu_issue  <= 1'b0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= '0;
            issue_id   <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            alu_issue <= grant_valid;
            if (grant_valid) begin
                alu_a      <= grant_id ? req1_a  : req0_a;
                alu_b      <= grant_id ? req1_b  : req0_b;
                alu_op     <= grant_id ? req1_op : req0_op;
                issue_id   <= grant_id;
                last_grant <= grant_id;
            end
        end
    end

    // The tag enters the pipe alongside the ALU issue strobe, so the pipe
    // head coincides with alu_result LAT cycles after alu_issue.
    assign issue_tag = '{valid: alu_issue, id: issue_id};

    alu_tag_pipe #(.LAT(LAT)) u_tag_pipe (
        .clk     (clk),
        .rst     (rst),
        .tag_in  (issue_tag),
        .tag_out (rsp_tag)
    );

    assign rsp_valid = rsp_tag.valid;
    assign rsp_id    = rsp_tag.id;
    assign rsp_data  = alu_result;
    assign rsp_flags = alu_flags;

    // Count operations held by the ALU: counted from the cycle they are
    // presented until their response, which bounds the count at LAT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight <= '0;
        end else begin
            case ({alu_issue, rsp_valid})
                2'b10:   inflight <= inflight + 4'd1;
                2'b01:   inflight <= inflight - 4'd1;
                default: inflight <= inflight;
            endcase
        end
    end

    // Saturating count of accepted operations since reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_cnt <= '0;
        end else if (grant_valid && (issue_cnt != '1)) begin
            issue_cnt <= issue_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Self-checking bench for alu_issue_arbiter: directed scenarios followed by
// random traffic, all checked against a transaction-level queue model.
module tb_alu_issue_arbiter;
    import alu_issue_arbiter_pkg::*;

    localparam int LAT = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       hold;
    logic       req0_valid, req1_valid;
    logic       req0_ready, req1_ready;
    logic [7:0] req0_a, req1_a;
    logic [4:0] req0_b, req1_b;
    logic [4:0] req0_op, req1_op;
    logic       alu_issue;
    logic [7:0] alu_a;
    logic [4:0] alu_b;
    logic [4:0] alu_op;
    logic [7:0] alu_result;
    logic [3:0] alu_flags;
    logic       rsp_valid, rsp_id;
    logic [7:0] rsp_data;
    logic [3:0] rsp_flags;
    logic [3:0] inflight;
    logic [15:0] issue_cnt;

    alu_issue_arbiter #(.DW(8), .BW(5), .OPW(5), .LAT(LAT), .CW(16)) dut (
        .clk(clk), .rst(rst), .hold(hold),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .alu_issue(alu_issue), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_flags(alu_flags),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_flags(rsp_flags),
        .inflight(inflight), .issue_cnt(issue_cnt)
    );

    always #5 clk = ~clk;

    // Reference ALU behaviour: returns {zero, neg, carry, overflow, result}.
    function automatic logic [11:0] alu_ref(input logic [7:0] a, input logic [4:0] b,
                                            input logic [4:0] op);
        logic [7:0]  bx;
        logic [8:0]  w;
        logic [12:0] p;
        logic [7:0]  r;
        logic        c, v;
        bx = {3'b000, b};
        c = 1'b0; v = 1'b0; r = 8'h00;
        case (op)
            OP_ADD: begin
                w = {1'b0, a} + {1'b0, bx}; r = w[7:0]; c = w[8];
                v = (a[7] == bx[7]) && (r[7] != a[7]);
            end
            OP_SUB: begin
                w = {1'b0, a} - {1'b0, bx}; r = w[7:0]; c = w[8];
                v = (a[7] != bx[7]) && (r[7] != a[7]);
            end
            OP_MUL: begin
                p = {5'b0, a} * {8'b0, b}; r = p[7:0]; c = |p[12:8];
            end
            OP_DIV: begin
                if (b == 5'd0) begin r = 8'hFF; v = 1'b1; end
                else r = a / bx;
            end
            OP_SHL: r = a << b;
            OP_SHR: r = a >> b;
            default: r = 8'h00;
        endcase
        return {(r == 8'h00), r[7], c, v, r};
    endfunction

    // Behavioural ALU: fixed latency LAT from alu_issue to alu_result.
    logic [11:0] alu_pipe [LAT];
    initial for (int i = 0; i < LAT; i++) alu_pipe[i] = '0;
    always @(posedge clk) begin
        alu_pipe[0] <= alu_ref(alu_a, alu_b, alu_op);
        for (int i = 1; i < LAT; i++) alu_pipe[i] <= alu_pipe[i-1];
    end
    assign alu_result = alu_pipe[LAT-1][7:0];
    assign alu_flags  = alu_pipe[LAT-1][11:8];

    // Transaction model: accepted operations waiting for their response.
    typedef struct {
        int         cyc;
        logic       id;
        logic [7:0] a;
        logic [4:0] b;
        logic [4:0] op;
    } exp_t;

    exp_t       q[$];
    logic       grant_log[$];
    logic       rsp_log[$];
    int         cyc = 0;
    int         peak = 0;
    int         checks = 0;
    int         errors = 0;
    logic       m_last = 1'b1;
    int         m_cnt = 0;
    logic       m_issue = 1'b0;
    logic [7:0] m_a = '0;
    logic [4:0] m_b = '0;
    logic [4:0] m_op = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock cycle: drive inputs at the falling edge, check outputs
    // shortly after, then advance the model by the rules of the protocol.
    task automatic cycle(input logic v0, input logic [7:0] a0, input logic [4:0] b0,
                         input logic [4:0] op0,
                         input logic v1, input logic [7:0] a1, input logic [4:0] b1,
                         input logic [4:0] op1,
                         input logic h, output logic acc0, output logic acc1);
        logic        g_valid, g_id, exp_rsp;
        logic [11:0] ref_val;
        int          n;
        req0_valid = v0; req0_a = a0; req0_b = b0; req0_op = op0;
        req1_valid = v1; req1_a = a1; req1_b = b1; req1_op = op1;
        hold = h;
        #2;
        g_valid = !h && (v0 || v1);
        g_id    = (v0 && v1) ? !m_last : v1;
        check("req0_ready", req0_ready, g_valid && !g_id);
        check("req1_ready", req1_ready, g_valid && g_id);
        check("alu_issue", alu_issue, m_issue);
        check("alu_a", alu_a, m_a);
        check("alu_b", alu_b, m_b);
        check("alu_op", alu_op, m_op);
        exp_rsp = (q.size() > 0) && (q[0].cyc + 1 + LAT == cyc);
        check("rsp_valid", rsp_valid, exp_rsp);
        if (exp_rsp) begin
            ref_val = alu_ref(q[0].a, q[0].b, q[0].op);
            check("rsp_id", rsp_id, q[0].id);
            check("rsp_data", rsp_data, ref_val[7:0]);
            check("rsp_flags", rsp_flags, ref_val[11:8]);
            rsp_log.push_back(rsp_id);
        end
        n = 0;
        foreach (q[i]) if (cyc >= q[i].cyc + 2) n++;
        check("inflight", inflight, n);
        if (int'(inflight) > peak) peak = int'(inflight);
        check("issue_cnt", issue_cnt, m_cnt);
        if (exp_rsp) void'(q.pop_front());
        m_issue = g_valid;
        acc0 = g_valid && !g_id;
        acc1 = g_valid && g_id;
        if (g_valid) begin
            m_a  = g_id ? a1 : a0;
            m_b  = g_id ? b1 : b0;
            m_op = g_id ? op1 : op0;
            m_last = g_id;
            q.push_back('{cyc: cyc, id: g_id, a: m_a, b: m_b, op: m_op});
            grant_log.push_back(g_id);
            if (m_cnt != 32'hFFFF) m_cnt++;
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic idle(input int n);
        logic x0, x1;
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, x0, x1);
    endtask

    // Asynchronous reset held for one cycle; checks the cleared state.
    task automatic do_reset();
        req0_valid = 0; req1_valid = 0; hold = 0;
        rst = 1'b1;
        #2;
        check("rst_alu_issue", alu_issue, 0);
        check("rst_alu_a", alu_a, 0);
        check("rst_alu_b", alu_b, 0);
        check("rst_alu_op", alu_op, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_id", rsp_id, 0);
        check("rst_inflight", inflight, 0);
        check("rst_issue_cnt", issue_cnt, 0);
        check("rst_last_grant", dut.last_grant, 1);
        q.delete();
        m_last = 1'b1; m_cnt = 0; m_issue = 1'b0;
        m_a = '0; m_b = '0; m_op = '0;
        @(negedge clk);
        rst = 1'b0;
        cyc++;
    endtask

    logic       x0, x1, p0, p1, hr;
    logic [7:0] ra0, ra1;
    logic [4:0] rb0, rb1, ro0, ro1;

    initial begin
        rst = 1'b0; hold = 1'b0;
        req0_valid = 0; req0_a = 0; req0_b = 0; req0_op = 0;
        req1_valid = 0; req1_a = 0; req1_b = 0; req1_op = 0;
        @(negedge clk);
        do_reset();

        // Single requester 0: 5 + 3 -> 8, no flags.
        cycle(1, 8'd5, 5'd3, OP_ADD, 0, 0, 0, 0, 0, x0, x1);
        idle(4);

        // Both requesters contending for six cycles.
        do_reset();
        grant_log.delete(); rsp_log.delete(); peak = 0;
        for (int i = 0; i < 6; i++)
            cycle(1, 8'(8'h20 + i), 5'(i + 1), OP_ADD, 1, 8'(8'h90 + i), 5'(2 * i), OP_MUL,
                  0, x0, x1);
        idle(4);
        check("rr_grant_count", grant_log.size(), 6);
        check("rr_rsp_count", rsp_log.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < grant_log.size()) check("rr_grant_order", grant_log[i], i % 2);
            if (i < rsp_log.size())   check("rr_rsp_order", rsp_log[i], i % 2);
        end
        check("rr_inflight_peak", peak, 2);
        check("rr_issue_cnt", issue_cnt, 16'd6);

        // Single requester 1: 0x10 - 0x10 -> zero flag.
        rsp_log.delete();
        cycle(0, 0, 0, 0, 1, 8'h10, 5'h10, OP_SUB, 0, x0, x1);
        idle(4);
        check("sub_rsp_count", rsp_log.size(), 1);

        // Hold for three cycles with both requesters waiting.
        for (int i = 0; i < 2; i++)
            cycle(1, 8'(8'h40 + i), 5'd9, OP_SHR, 1, 8'(8'hC0 + i), 5'd0, OP_DIV, 0, x0, x1);
        for (int i = 0; i < 3; i++)
            cycle(1, 8'h55, 5'd1, OP_SHL, 1, 8'hAA, 5'd3, OP_SUB, 1, x0, x1);
        for (int i = 0; i < 2; i++)
            cycle(1, 8'h55, 5'd1, OP_SHL, 1, 8'hAA, 5'd3, OP_SUB, 0, x0, x1);
        idle(4);

        // Reset while two operations are in flight; their responses vanish.
        cycle(1, 8'h7F, 5'd1, OP_ADD, 0, 0, 0, 0, 0, x0, x1);
        cycle(1, 8'h80, 5'd1, OP_SUB, 0, 0, 0, 0, 0, x0, x1);
        do_reset();
        idle(5);
        cycle(1, 8'd12, 5'd4, OP_MUL, 0, 0, 0, 0, 0, x0, x1);
        idle(4);

        // Saturation of the issue counter.
        force dut.issue_cnt = 16'hFFFE;
        #1;
        release dut.issue_cnt;
        m_cnt = 32'hFFFE;
        for (int i = 0; i < 3; i++)
            cycle(1, 8'(i), 5'(i), OP_ADD, 0, 0, 0, 0, 0, x0, x1);
        idle(3);
        check("sat_issue_cnt", issue_cnt, 16'hFFFF);

        // Random traffic with withdrawals and hold.
        p0 = 0; p1 = 0; ra0 = 0; ra1 = 0; rb0 = 0; rb1 = 0; ro0 = 0; ro1 = 0;
        for (int i = 0; i < 300; i++) begin
            if (!p0) begin
                p0 = 1'($urandom_range(0, 1));
                ra0 = 8'($urandom); rb0 = 5'($urandom); ro0 = 5'($urandom_range(0, 7));
            end else if ($urandom_range(0, 7) == 0) p0 = 0;
            if (!p1) begin
                p1 = 1'($urandom_range(0, 1));
                ra1 = 8'($urandom); rb1 = 5'($urandom); ro1 = 5'($urandom_range(0, 7));
            end else if ($urandom_range(0, 7) == 0) p1 = 0;
            hr = ($urandom_range(0, 4) == 0);
            cycle(p0, ra0, rb0, ro0, p1, ra1, rb1, ro1, hr, x0, x1);
            if (x0) p0 = 0;
            if (x1) p1 = 0;
        end
        idle(LAT + 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
